usb_transmitter: RTL and testbench

USB_TRANSMITTER -- requirements
Module: usb_transmitter

---
 rtl/usb_pkg.sv | 22 ++
 rtl/usb_tx_nrzi.sv | 41 ++++
 rtl/usb_transmitter.sv | 209 ++++++++++++++++++++
 tb/tb_usb_transmitter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB full-speed definitions: FSM states, line levels and bit-level constants.
// Used by both the transmitter and the receiver.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } usb_state_e;

  // Line states encoded as {dp, dn}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam int         STUFF_LIMIT = 6;
  localparam int         ONES_W      = 3;

endpackage

// File: rtl/usb_tx_nrzi.sv
// NRZI encoder with bit stuffing. On each step it emits either the offered bit
// (bit_accept=1) or, after STUFF_LIMIT consecutive ones, a stuffed 0 (bit_accept=0).
module usb_tx_nrzi
  import usb_pkg::*;
(
  input  logic clock48,
  input  logic reset_n,
  input  logic clear,
  input  logic step,
  input  logic bit_in,
  output logic bit_accept,
  output logic stuff_pending,
  output logic line_j
);

  logic [ONES_W-1:0] ones_r;
  logic              line_j_r;

  assign stuff_pending = (ones_r == ONES_W'(STUFF_LIMIT));
  assign bit_accept    = step & ~stuff_pending;
  assign line_j        = line_j_r;

  // Line level and run-of-ones counter; any 0 (data or stuffed) toggles the line and clears the run
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      ones_r   <= '0;
      line_j_r <= 1'b1;
    end else if (clear) begin
      ones_r   <= '0;
      line_j_r <= 1'b1;
    end else if (step) begin
      if (stuff_pending || !bit_in) begin
        line_j_r <= ~line_j_r;
        ones_r   <= '0;
      end else begin
        ones_r   <= ones_r + ONES_W'(1);
      end
    end
  end

endmodule

// File: rtl/usb_transmitter.sv
// USB full-speed packet transmitter: byte stream in, SYNC + NRZI/stuffed data + EOP out.
// One holding register feeds the shift register at each byte boundary.
module usb_transmitter
  import usb_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_underrun,
  output logic       usb_dp_out,
  output logic       usb_dn_out,
  output logic       usb_oe
);

  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  usb_state_e       state_r, state_next_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [7:0]       shift_r, hold_r, next_byte_s;
  logic [2:0]       bits_left_r;
  logic             hold_full_r, hold_last_r, cur_last_r, next_last_s;
  logic             eop_cnt_r, done_r, underrun_r;
  logic             bit_end_s, accept_s, tx_ready_s;
  logic             step_s, step_bit_s, load_s, enter_eop_s, underrun_s, clear_s;
  logic             bit_accept_s, stuff_pending_s, line_j_s;
  logic [1:0]       line_s;
  logic             oe_s, busy_s;

  assign bit_end_s   = (bit_cnt_r == CNT_W'(CLOCKS_PER_BIT - 1));
  assign accept_s    = tx_valid & tx_ready_s;
  assign next_byte_s = hold_full_r ? hold_r : tx_data;
  assign next_last_s = hold_full_r ? hold_last_r : tx_last;
  assign clear_s     = ~step_s & ~((state_r == ST_SYNC) | (state_r == ST_DATA));

  usb_tx_nrzi u_nrzi (
    .clock48       (clock48),
    .reset_n       (reset_n),
    .clear         (clear_s),
    .step          (step_s),
    .bit_in        (step_bit_s),
    .bit_accept    (bit_accept_s),
    .stuff_pending (stuff_pending_s),
    .line_j        (line_j_s)
  );

  // State register
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state plus per-bit strobes; a pending stuff bit always goes out before a boundary decision
  always_comb begin
    state_next_s = state_r;
    step_s       = 1'b0;
    step_bit_s   = 1'b0;
    load_s       = 1'b0;
    enter_eop_s  = 1'b0;
    underrun_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_SYNC;
          step_s       = 1'b1;
          step_bit_s   = SYNC_BYTE[0];
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (!bit_end_s) begin
          state_next_s = state_r;
        end else if (stuff_pending_s || (bits_left_r != 3'd0)) begin
          step_s     = 1'b1;
          step_bit_s = shift_r[0];
        end else if (cur_last_r) begin
          state_next_s = ST_EOP_SE0;
          enter_eop_s  = 1'b1;
        end else if (hold_full_r || accept_s) begin
          state_next_s = ST_DATA;
          step_s       = 1'b1;
          step_bit_s   = next_byte_s[0];
          load_s       = 1'b1;
        end else begin
          state_next_s = ST_EOP_SE0;
          enter_eop_s  = 1'b1;
          underrun_s   = 1'b1;
        end
      end
      ST_EOP_SE0: begin
        if (bit_end_s && !eop_cnt_r) begin
          state_next_s = ST_EOP_J;
        end else begin
          state_next_s = ST_EOP_SE0;
        end
      end
      ST_EOP_J: begin
        if (bit_end_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_EOP_J;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state only
  always_comb begin
    line_s     = LINE_J;
    oe_s       = 1'b0;
    busy_s     = 1'b0;
    tx_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_ready_s = 1'b1;
      end
      ST_SYNC, ST_DATA: begin
        line_s     = line_j_s ? LINE_J : LINE_K;
        oe_s       = 1'b1;
        busy_s     = 1'b1;
        tx_ready_s = ~hold_full_r & ~cur_last_r;
      end
      ST_EOP_SE0: begin
        line_s = LINE_SE0;
        oe_s   = 1'b1;
        busy_s = 1'b1;
      end
      ST_EOP_J: begin
        line_s = LINE_J;
        oe_s   = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        line_s = LINE_J;
      end
    endcase
  end

  // Datapath: bit timer, shift/holding registers, EOP length and status pulses
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r   <= '0;
      shift_r     <= 8'h00;
      bits_left_r <= 3'd0;
      cur_last_r  <= 1'b0;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      hold_last_r <= 1'b0;
      eop_cnt_r   <= 1'b0;
      done_r      <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) || bit_end_s) begin
        bit_cnt_r <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
      // IDLE keeps SYNC preloaded; its first bit leaves on the accepting edge
      if (state_r == ST_IDLE) begin
        shift_r     <= {1'b0, SYNC_BYTE[7:1]};
        bits_left_r <= 3'd7;
        cur_last_r  <= 1'b0;
      end else if (load_s) begin
        shift_r     <= {1'b0, next_byte_s[7:1]};
        bits_left_r <= 3'd7;
        cur_last_r  <= next_last_s;
      end else if (bit_accept_s) begin
        shift_r     <= {1'b0, shift_r[7:1]};
        bits_left_r <= bits_left_r - 3'd1;
      end
      if (accept_s && !load_s) begin
        hold_r      <= tx_data;
        hold_full_r <= 1'b1;
        hold_last_r <= tx_last;
      end else if (load_s) begin
        hold_full_r <= 1'b0;
      end
      if (enter_eop_s) begin
        eop_cnt_r <= 1'b1;
      end else if ((state_r == ST_EOP_SE0) && bit_end_s) begin
        eop_cnt_r <= 1'b0;
      end
      done_r     <= (state_r == ST_EOP_J) && bit_end_s;
      underrun_r <= underrun_s;
    end
  end

  assign tx_ready    = tx_ready_s;
  assign busy        = busy_s;
  assign usb_oe      = oe_s;
  assign usb_dp_out  = line_s[1];
  assign usb_dn_out  = line_s[0];
  assign tx_done     = done_r;
  assign tx_underrun = underrun_r;

endmodule

// File: tb/tb_usb_transmitter.sv
// Scoreboard bench for usb_transmitter: stimulus queues hand-computed line symbols and
// decoded bytes; a negedge monitor captures each packet and checks it on tx_done.
module tb_usb_transmitter;

  localparam int CPB = 4;

  logic       clock48 = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last;
  logic       tx_ready, busy, tx_done, tx_underrun;
  logic       usb_dp_out, usb_dn_out, usb_oe;

  usb_transmitter #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock48     (clock48),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun),
    .usb_dp_out  (usb_dp_out),
    .usb_dn_out  (usb_dn_out),
    .usb_oe      (usb_oe)
  );

  always #5 clock48 = ~clock48;

  int    total = 0;
  int    bad = 0;
  string exp_line_q[$];
  string exp_hex_q[$];
  int    exp_ur_q[$];
  int    exp_acc_q[$];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_str(string name, string act, string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got '%s' want '%s'", name, act, exp);
    end
  endfunction

  // Receiver model: NRZI decode from idle J, drop stuffed bits, pack LSB-first bytes as hex
  function automatic string decode(string s);
    string      hex = "";
    string      c;
    string      prev = "J";
    logic [7:0] acc = 8'h00;
    int         nb = 0;
    int         ones = 0;
    logic       b;
    for (int i = 0; i < s.len(); i++) begin
      c = s.substr(i, i);
      if (c == "0") break;
      b = (c == prev);
      prev = c;
      if (ones == 6) begin
        ones = 0;
        if (b) hex = $sformatf("%s!", hex);
      end else begin
        ones = b ? ones + 1 : 0;
        acc[nb] = b;
        nb++;
        if (nb == 8) begin
          hex = $sformatf("%s%02x", hex, acc);
          nb = 0;
          acc = 8'h00;
        end
      end
    end
    if (nb != 0) hex = $sformatf("%s?", hex);
    return hex;
  endfunction

  int    cyc = 0;
  int    oe_cnt = 0;
  int    ur_cnt = 0;
  int    acc_cnt = 0;
  int    last_done_cyc = -100;
  logic  prev_oe = 1'b0;
  logic  glitch = 1'b0;
  string cap = "";
  string cur = "";

  // Monitor: one symbol per bit time (must be stable across it), packet checked on tx_done
  always @(negedge clock48) begin
    string sym;
    cyc++;
    if (!reset_n) begin
      cap = "";
      oe_cnt = 0;
      ur_cnt = 0;
      acc_cnt = 0;
      prev_oe = 1'b0;
    end else begin
      if (tx_done) begin
        if (exp_line_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got tx_done with line '%s' want no packet", cap);
        end else begin
          chk_str("line", cap, exp_line_q[0]);
          chk("oe_cycles", oe_cnt, exp_line_q[0].len() * CPB);
          chk_str("decoded", decode(cap), exp_hex_q.pop_front());
          chk("underruns", ur_cnt, exp_ur_q.pop_front());
          chk("accepts", acc_cnt, exp_acc_q.pop_front());
          chk("done_after_oe", int'({prev_oe, usb_oe}), 2);
          void'(exp_line_q.pop_front());
        end
        last_done_cyc = cyc;
        cap = "";
        oe_cnt = 0;
        ur_cnt = 0;
        acc_cnt = 0;
      end
      if (usb_oe && !prev_oe) chk("sync_gap", int'(cyc - last_done_cyc >= 1), 1);
      if (usb_oe) begin
        if (usb_dp_out && !usb_dn_out) sym = "J";
        else if (!usb_dp_out && usb_dn_out) sym = "K";
        else if (!usb_dp_out && !usb_dn_out) sym = "0";
        else sym = "X";
        if (oe_cnt % CPB == 0) begin
          cur = sym;
          glitch = 1'b0;
        end else if (sym != cur) begin
          glitch = 1'b1;
        end
        if (oe_cnt % CPB == CPB - 1) cap = $sformatf("%s%s", cap, glitch ? "X" : cur);
        oe_cnt++;
      end
      if (tx_underrun) ur_cnt++;
      if (tx_valid && tx_ready) acc_cnt++;
      prev_oe = usb_oe;
    end
  end

  task automatic expect_pkt(input string line, input string hex, input int ur, input int acc);
    exp_line_q.push_back(line);
    exp_hex_q.push_back(hex);
    exp_ur_q.push_back(ur);
    exp_acc_q.push_back(acc);
  endtask

  // Offer n bytes (byte 0 in bits 7:0), each as soon as tx_ready is seen
  task automatic send(input logic [31:0] bytes, input int n, input logic is_last);
    int waitc;
    for (int i = 0; i < n; i++) begin
      tx_data  = bytes[8*i +: 8];
      tx_last  = is_last && (i == n - 1);
      tx_valid = 1'b1;
      waitc = 0;
      @(negedge clock48);
      while (!tx_ready && waitc < 400) begin
        @(negedge clock48);
        waitc++;
      end
      if (!tx_ready) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: byte %0d tx_ready=0 want 1", i);
      end
      @(posedge clock48);
      #1;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
    end
  endtask

  task automatic wait_all(input int budget);
    int c = 0;
    while (exp_line_q.size() != 0 && c < budget) begin
      @(negedge clock48);
      c++;
    end
    total++;
    if (exp_line_q.size() != 0) begin
      bad++;
      $display("FAIL packet_timeout: got %0d packets outstanding want 0", exp_line_q.size());
    end
    repeat (3) @(posedge clock48);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (3) @(posedge clock48);
    #1;
    chk("rst_oe", usb_oe, 0);
    chk("rst_dp", usb_dp_out, 1);
    chk("rst_dn", usb_dn_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_done", tx_done, 0);
    chk("rst_underrun", tx_underrun, 0);
    reset_n = 1'b1;
    @(posedge clock48);
    #1;

    expect_pkt("KJKJKJKKJKJKJKJK00J", "8000", 0, 1);
    send(32'h0000_0000, 1, 1'b1);
    wait_all(300);

    expect_pkt("KJKJKJKKKKKKKJJJJ00J", "80ff", 0, 1);
    send(32'h0000_00ff, 1, 1'b1);
    wait_all(300);

    expect_pkt("KJKJKJKKKJKJKJKJKKJKJKJKKKJKJKJK00J", "80010203", 0, 3);
    send(32'h0003_0201, 3, 1'b1);
    wait_all(400);

    expect_pkt("KJKJKJKKKJJKJJKK00J", "80a5", 1, 1);
    send(32'h0000_00a5, 1, 1'b0);
    wait_all(300);

    // Abort mid-DATA: packet abandoned, no EOP, no done
    send(32'h0000_0000, 1, 1'b1);
    repeat (40) @(posedge clock48);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_oe", usb_oe, 0);
    chk("mid_rst_dp", usb_dp_out, 1);
    chk("mid_rst_dn", usb_dn_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    repeat (2) @(posedge clock48);
    #1;
    chk("mid_rst_done", tx_done, 0);
    chk("mid_rst_underrun", tx_underrun, 0);
    @(negedge clock48);
    reset_n = 1'b1;
    @(posedge clock48);
    #1;
    expect_pkt("KJKJKJKKJKJKJKJK00J", "8000", 0, 1);
    send(32'h0000_0000, 1, 1'b1);
    wait_all(300);

    // Back-to-back: second byte waits through EOP, accepted in the tx_done cycle at the earliest
    expect_pkt("KJKJKJKKJKKKKKJK00J", "803c", 0, 1);
    expect_pkt("KJKJKJKKKKJKJKKK00J", "80c3", 0, 1);
    send(32'h0000_003c, 1, 1'b1);
    send(32'h0000_00c3, 1, 1'b1);
    wait_all(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
